// File: rtl/det_nxn_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// det_nxn_seq
//
// Sequential signed-integer determinant engine for an NxN matrix using
// fraction-free Bareiss elimination. The host loads the matrix one element
// at a time, pulses start, and reads det/singular when done pulses. A zero
// pivot is handled by swapping in the first lower row with a non-zero entry
// in the pivot column. If no such row exists, the matrix is singular and det
// is forced to 0.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   wr_en     element write strobe (ignored while busy)
//   wr_addr   row-major element index r*N+c (indices >= N*N ignored)
//   wr_data   signed element value
//   start     begin computation (ignored while busy)
//   det       signed determinant, valid from done until the next start
//   singular  det == 0, same validity as det
//   busy      high from the cycle after an accepted start through done
//   done      one-cycle pulse when det/singular update
// ---------------------------------------------------------------------------
module det_nxn_seq #(
    parameter  int N  = 3,
    parameter  int W  = 32,
    localparam int DW = N * W + 5,
    localparam int AW = $clog2(N * N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [W-1:0]  wr_data,
    input  logic                 start,
    output logic signed [DW-1:0] det,
    output logic                 singular,
    output logic                 busy,
    output logic                 done
);

    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int TW  = 2 * DW;
    localparam int CW  = $clog2(DW);
    localparam int AW1 = AW + 1;

    localparam logic [IW-1:0]  LAST     = IW'(N - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
    localparam logic [AW1-1:0] NN       = AW1'(N * N);

    if (N < 2 || N > 4) begin : g_bad_n
        $error("det_nxn_seq: N must be in 2..4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIVOT,
        S_SWAP,
        S_UPDATE,
        S_DIV,
        S_FINISH
    } state_t;

    state_t state;

    logic signed [W-1:0]  a     [N*N];  // host-loaded matrix
    logic signed [W-1:0]  a_nxt [N*N];  // a with this cycle's write applied
    logic signed [DW-1:0] b     [N][N]; // working matrix

    logic [IW-1:0]        k, i, j, r;
    logic signed [DW-1:0] prev;         // previous pivot (Bareiss divisor)
    logic                 neg;          // odd number of row swaps
    logic                 forced;       // no pivot found: det is 0
    logic                 q_neg;        // sign of the pending quotient
    logic [DW-1:0]        rem, quo;     // restoring-divide remainder / quotient
    logic [CW-1:0]        cnt;

    // Combinational helpers
    logic                 wr_ok;
    logic [IW-1:0]        k_inc, i_inc, j_inc, r_inc;
    logic                 last_i, last_j, step_end;
    logic [IW-1:0]        adv_i, adv_j;
    state_t               adv_state;
    logic signed [TW-1:0] t;
    logic [TW-1:0]        t_abs;
    logic [DW-1:0]        prev_abs;
    logic [DW:0]          shifted, diff;
    logic                 ge;
    logic [DW-1:0]        rem_nxt, quo_nxt, q_res;
    logic signed [DW-1:0] fin_val;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        wr_ok = wr_en && !busy && ({1'b0, wr_addr} < NN);
        for (int e = 0; e < N * N; e++) begin
            a_nxt[e] = a[e];
        end
        if (wr_ok) begin
            a_nxt[wr_addr] = wr_data;
        end

        k_inc = k + IW'(1);
        i_inc = i + IW'(1);
        j_inc = j + IW'(1);
        r_inc = r + IW'(1);

        // Element walk: j fastest, then i, both over k+1..N-1.
        last_i    = (i == LAST);
        last_j    = (j == LAST);
        step_end  = last_i && last_j;
        adv_j     = last_j ? k_inc : j_inc;
        adv_i     = last_j ? i_inc : i;
        adv_state = !step_end ? S_UPDATE : ((k_inc == LAST) ? S_FINISH : S_PIVOT);

        // Bareiss cross product at full double width, before the exact divide.
        t = TW'(b[i][j]) * TW'(b[k][k]) - TW'(b[i][k]) * TW'(b[k][j]);
        t_abs    = t[TW-1] ? -t : t;
        prev_abs = prev[DW-1] ? -prev : prev;

        // One restoring-divide step. The quotient fits in DW bits, so the
        // upper half of the dividend is always below the divisor and a
        // DW+1 bit partial remainder suffices.
        shifted = {rem, quo[DW-1]};
        diff    = shifted - {1'b0, prev_abs};
        ge      = (shifted >= {1'b0, prev_abs});
        rem_nxt = ge ? diff[DW-1:0] : shifted[DW-1:0];
        quo_nxt = {quo[DW-2:0], ge};
        q_res   = q_neg ? -quo_nxt : quo_nxt;

        fin_val = neg ? -b[N-1][N-1] : b[N-1][N-1];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            det      <= '0;
            singular <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            r        <= '0;
            prev     <= DW'(1);
            neg      <= 1'b0;
            forced   <= 1'b0;
            q_neg    <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            // NOTE: both matrices are architecturally visible after reset
            // (a restart must see zeros), so they are reset like any register.
            for (int e = 0; e < N * N; e++) begin
                a[e] <= '0;
            end
            for (int rr = 0; rr < N; rr++) begin
                for (int cc = 0; cc < N; cc++) begin
                    b[rr][cc] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            for (int e = 0; e < N * N; e++) begin
                a[e] <= a_nxt[e];
            end

            case (state)
                S_IDLE: begin
                    // busy stays high through the done cycle and drops here.
                    busy <= 1'b0;
                    if (start && !busy) begin
                        // Load from a_nxt so a same-cycle write is included.
                        for (int rr = 0; rr < N; rr++) begin
                            for (int cc = 0; cc < N; cc++) begin
                                b[rr][cc] <= DW'(a_nxt[AW'(rr * N + cc)]);
                            end
                        end
                        k      <= '0;
                        r      <= '0;
                        prev   <= DW'(1);
                        neg    <= 1'b0;
                        forced <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_PIVOT;
                    end
                end

                S_PIVOT: begin
                    // r starts at k; each cycle tests one row of column k.
                    if (b[r][k] != '0) begin
                        i     <= k_inc;
                        j     <= k_inc;
                        state <= (r == k) ? S_UPDATE : S_SWAP;
                    end else if (r == LAST) begin
                        forced <= 1'b1;
                        state  <= S_FINISH;
                    end else begin
                        r <= r_inc;
                    end
                end

                S_SWAP: begin
                    for (int cc = 0; cc < N; cc++) begin
                        b[k][cc] <= b[r][cc];
                        b[r][cc] <= b[k][cc];
                    end
                    neg   <= !neg;
                    state <= S_UPDATE;
                end

                S_UPDATE: begin
                    if (k == '0) begin
                        // prev is 1 on the first step: no divide needed.
                        b[i][j] <= t[DW-1:0];
                        i       <= adv_i;
                        j       <= adv_j;
                        state   <= adv_state;
                        if (step_end) begin
                            prev <= b[k][k];
                            k    <= k_inc;
                            r    <= k_inc;
                        end
                    end else begin
                        rem   <= t_abs[TW-1:DW];
                        quo   <= t_abs[DW-1:0];
                        q_neg <= t[TW-1] ^ prev[DW-1];
                        cnt   <= '0;
                        state <= S_DIV;
                    end
                end

                S_DIV: begin
                    if (cnt == CNT_LAST) begin
                        b[i][j] <= q_res;
                        i       <= adv_i;
                        j       <= adv_j;
                        state   <= adv_state;
                        if (step_end) begin
                            prev <= b[k][k];
                            k    <= k_inc;
                            r    <= k_inc;
                        end
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + CW'(1);
                    end
                end

                S_FINISH: begin
                    det      <= forced ? '0 : fin_val;
                    singular <= forced || (fin_val == '0);
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_det_nxn_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_det_nxn_seq
//
// Directed bench for det_nxn_seq. Two instances: N=3 and N=4, both W=32,
// sharing clock and reset. Each scenario task drives its own stimulus and
// compares results against hand-computed determinants.
// ---------------------------------------------------------------------------
module tb_det_nxn_seq;

    localparam int W      = 32;
    localparam int DW3    = 3 * W + 5;
    localparam int AW3    = 4;
    localparam int DW4    = 4 * W + 5;
    localparam int AW4    = 4;
    localparam int BOUND3 = 520;
    localparam int BOUND4 = 1898;

    logic clk = 1'b0;
    logic reset;

    logic                  wr_en3, start3;
    logic [AW3-1:0]        wr_addr3;
    logic signed [W-1:0]   wr_data3;
    logic signed [DW3-1:0] det3;
    logic                  singular3, busy3, done3;

    logic                  wr_en4, start4;
    logic [AW4-1:0]        wr_addr4;
    logic signed [W-1:0]   wr_data4;
    logic signed [DW4-1:0] det4;
    logic                  singular4, busy4, done4;

    int tests = 0;
    int fails = 0;
    int done_cnt3 = 0;
    int mat3 [9];

    det_nxn_seq #(.N(3), .W(W)) u_dut3 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en3),
        .wr_addr  (wr_addr3),
        .wr_data  (wr_data3),
        .start    (start3),
        .det      (det3),
        .singular (singular3),
        .busy     (busy3),
        .done     (done3)
    );

    det_nxn_seq #(.N(4), .W(W)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en4),
        .wr_addr  (wr_addr4),
        .wr_data  (wr_data4),
        .start    (start4),
        .det      (det4),
        .singular (singular4),
        .busy     (busy4),
        .done     (done4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done3 === 1'b1) done_cnt3 <= done_cnt3 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write3(input int addr, input int data);
        wr_en3   = 1'b1;
        wr_addr3 = AW3'(addr);
        wr_data3 = W'(data);
        tick();
        wr_en3   = 1'b0;
    endtask

    task automatic load3();
        for (int e = 0; e < 9; e++) write3(e, mat3[e]);
    endtask

    task automatic write4(input int addr, input int data);
        wr_en4   = 1'b1;
        wr_addr4 = AW4'(addr);
        wr_data4 = W'(data);
        tick();
        wr_en4   = 1'b0;
    endtask

    // Pulse start, then wait (bounded) for done. cyc = edges from accept to done.
    task automatic run3(output int cyc, output logic busy_seen);
        start3 = 1'b1;
        tick();
        start3    = 1'b0;
        busy_seen = busy3;
        cyc       = 0;
        while (done3 !== 1'b1 && cyc < BOUND3 + 10) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run4(output int cyc);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cyc    = 0;
        while (done4 !== 1'b1 && cyc < BOUND4 + 10) begin
            tick();
            cyc++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        tests++;
        if (det3 !== '0 || singular3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
            fails++;
            $display("FAIL reset_n3: det=%0d sing=%b busy=%b done=%b, required 0 0 0 0",
                     det3, singular3, busy3, done3);
        end
        tests++;
        if (det4 !== '0 || singular4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_n4: det=%0d sing=%b busy=%b done=%b, required 0 0 0 0",
                     det4, singular4, busy4, done4);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int   cyc;
        logic bs;
        logic signed [DW3-1:0] exp3;
        mat3 = '{-5, -5, -5, -5, -5, -4, -5, -3, -5};
        load3();
        run3(cyc, bs);
        exp3 = DW3'(10);
        tests++;
        if (bs !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b, required 1", bs);
        end
        tests++;
        if (done3 !== 1'b1 || cyc > BOUND3) begin
            fails++;
            $display("FAIL latency_basic: got %0d cycles (done=%b), required <= %0d", cyc, done3, BOUND3);
        end
        tests++;
        if (det3 !== exp3 || singular3 !== 1'b0) begin
            fails++;
            $display("FAIL det_basic: got det=%0d sing=%b, required det=%0d sing=0", det3, singular3, exp3);
        end
        tick();
        tests++;
        if (done3 !== 1'b0 || busy3 !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: got done=%b busy=%b one cycle later, required 0 0", done3, busy3);
        end
        tests++;
        if (det3 !== exp3) begin
            fails++;
            $display("FAIL det_hold: got %0d, required %0d", det3, exp3);
        end
    endtask

    task automatic test_swap();
        int   cyc;
        logic bs;
        logic signed [DW3-1:0] exp3;
        exp3 = DW3'(-1);
        mat3 = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
        load3();
        for (int run = 0; run < 2; run++) begin
            run3(cyc, bs);
            tests++;
            if (done3 !== 1'b1 || cyc > BOUND3) begin
                fails++;
                $display("FAIL latency_swap%0d: got %0d cycles, required <= %0d", run, cyc, BOUND3);
            end
            tests++;
            if (det3 !== exp3 || singular3 !== 1'b0) begin
                fails++;
                $display("FAIL det_swap%0d: got det=%0d sing=%b, required det=-1 sing=0", run, det3, singular3);
            end
            tick();
        end
    endtask

    task automatic test_singular();
        int   cyc;
        logic bs;
        mat3 = '{1, 2, 3, 4, 5, 6, 1, 2, 3};
        load3();
        run3(cyc, bs);
        tests++;
        if (done3 !== 1'b1 || det3 !== '0 || singular3 !== 1'b1) begin
            fails++;
            $display("FAIL det_dup_rows: got det=%0d sing=%b done=%b, required det=0 sing=1 done=1",
                     det3, singular3, done3);
        end
        tick();
        mat3 = '{0, 0, 1, 0, 2, 0, 0, 0, 3};
        load3();
        run3(cyc, bs);
        tests++;
        if (done3 !== 1'b1 || det3 !== '0 || singular3 !== 1'b1) begin
            fails++;
            $display("FAIL det_zero_col: got det=%0d sing=%b done=%b, required det=0 sing=1 done=1",
                     det3, singular3, done3);
        end
        tick();
    endtask

    task automatic test_n4();
        int cyc;
        logic signed [DW4-1:0] exp4;
        for (int e = 0; e < 16; e++) write4(e, (e % 5 == 0) ? 2 : 0);
        run4(cyc);
        exp4 = DW4'(16);
        tests++;
        if (done4 !== 1'b1 || cyc > BOUND4) begin
            fails++;
            $display("FAIL latency_n4: got %0d cycles, required <= %0d", cyc, BOUND4);
        end
        tests++;
        if (det4 !== exp4 || singular4 !== 1'b0) begin
            fails++;
            $display("FAIL det_n4_diag2: got det=%0d sing=%b, required det=16 sing=0", det4, singular4);
        end
        tick();
        for (int e = 0; e < 16; e++) write4(e, (e % 5 == 0) ? 32'sh8000_0000 : 0);
        run4(cyc);
        exp4      = '0;
        exp4[124] = 1'b1;
        tests++;
        if (done4 !== 1'b1 || det4 !== exp4 || singular4 !== 1'b0) begin
            fails++;
            $display("FAIL det_n4_min: got det=%0h sing=%b done=%b, required det=%0h sing=0",
                     det4, singular4, done4, exp4);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   cnt0;
        logic bs;
        logic signed [DW3-1:0] exp3;
        exp3 = DW3'(10);
        mat3 = '{-5, -5, -5, -5, -5, -4, -5, -3, -5};
        load3();
        cnt0   = done_cnt3;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (4) tick();
        start3 = 1'b1;         // ignored: engine is busy
        tick();
        start3 = 1'b0;
        write3(0, 7);          // ignored: engine is busy
        cyc = 0;
        while (done3 !== 1'b1 && cyc < BOUND3 + 10) begin
            tick();
            cyc++;
        end
        tests++;
        if (det3 !== exp3 || done3 !== 1'b1) begin
            fails++;
            $display("FAIL det_midrun: got det=%0d done=%b, required det=10 done=1", det3, done3);
        end
        repeat (4) tick();
        tests++;
        if (done_cnt3 - cnt0 !== 1) begin
            fails++;
            $display("FAIL done_count_midrun: got %0d done pulses, required 1", done_cnt3 - cnt0);
        end
        tests++;
        if (busy3 !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_ignored_start: got %b, required 0", busy3);
        end
        run3(cyc, bs);
        tests++;
        if (done3 !== 1'b1 || det3 !== exp3) begin
            fails++;
            $display("FAIL det_rerun_after_busy_write: got det=%0d done=%b, required det=10 done=1",
                     det3, done3);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        int   cyc;
        logic bs;
        logic signed [DW3-1:0] exp3;
        exp3   = DW3'(10);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        #1;
        tests++;
        if (det3 !== '0 || busy3 !== 1'b0 || done3 !== 1'b0 || singular3 !== 1'b0) begin
            fails++;
            $display("FAIL reset_midrun: got det=%0d busy=%b done=%b sing=%b, required all 0",
                     det3, busy3, done3, singular3);
        end
        reset = 1'b0;
        tick();
        // Matrix was cleared by reset: an immediate run sees all zeros.
        run3(cyc, bs);
        tests++;
        if (done3 !== 1'b1 || det3 !== '0 || singular3 !== 1'b1) begin
            fails++;
            $display("FAIL det_after_reset_cleared: got det=%0d sing=%b done=%b, required det=0 sing=1 done=1",
                     det3, singular3, done3);
        end
        tick();
        load3();
        write3(9, 99);         // out of range: ignored
        run3(cyc, bs);
        tests++;
        if (done3 !== 1'b1 || cyc > BOUND3 || det3 !== exp3 || singular3 !== 1'b0) begin
            fails++;
            $display("FAIL det_after_reload: got det=%0d sing=%b cyc=%0d, required det=10 sing=0",
                     det3, singular3, cyc);
        end
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        wr_en3   = 1'b0;
        start3   = 1'b0;
        wr_addr3 = '0;
        wr_data3 = '0;
        wr_en4   = 1'b0;
        start4   = 1'b0;
        wr_addr4 = '0;
        wr_data4 = '0;

        test_reset();
        test_basic();
        test_swap();
        test_singular();
        test_n4();
        test_back_to_back();
        test_reset_midrun();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
